// File: rtl/pipelined_adder_if.sv
// Handshake bundle for the pipelined add/subtract unit: operand beat in, result beat out.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, a, b, carry_in, op_sub, out_ready,
    input  in_ready, out_valid, y, carry_out, overflow, zero
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, carry_in, op_sub, out_ready,
    output in_ready, out_valid, y, carry_out, overflow, zero
  );

endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. The carry chain is cut into STAGES segments of SEG bits; each
// stage register holds a skewed word whose low segments are finished result bits and whose
// high segments are still the untouched A operand, plus the conditioned B operand and the
// carry into the next segment. The whole pipe advances or stalls as one.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus_io
);

  localparam int unsigned SEG = WIDTH / STAGES;

  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [STAGES-1:0] cry_q, cry_d;
  logic [STAGES-1:0] vld_q, vld_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  // Global shift enable: the pipe moves only when the final stage is empty or being drained.
  always_comb begin
    advance = !vld_q[STAGES-1] || bus_io.out_ready;
  end

  // Subtraction is folded into the adder as a + ~b + ~borrow_in.
  always_comb begin
    b_eff   = bus_io.op_sub ? ~bus_io.b : bus_io.b;
    cin_eff = bus_io.op_sub ? ~bus_io.carry_in : bus_io.carry_in;
  end

  // Per-stage segment add and next-state selection (hold everything on stall).
  always_comb begin : stage_comb
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] nacc;
    logic             pc;
    logic             pv;
    logic [SEG-1:0]   a_seg;
    logic [SEG-1:0]   b_seg;
    logic [SEG:0]     sum;
    int unsigned      pk;

    acc_d  = acc_q;
    opb_d  = opb_q;
    cry_d  = cry_q;
    vld_d  = vld_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    pa     = '0;
    pb     = '0;
    nacc   = '0;
    pc     = 1'b0;
    pv     = 1'b0;
    a_seg  = '0;
    b_seg  = '0;
    sum    = '0;
    pk     = 0;

    for (int unsigned k = 0; k < STAGES; k++) begin
      pk = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        pa = bus_io.a;
        pb = b_eff;
        pc = cin_eff;
        pv = bus_io.in_valid;
      end else begin
        pa = acc_q[pk];
        pb = opb_q[pk];
        pc = cry_q[pk];
        pv = vld_q[pk];
      end
      a_seg = SEG'(pa >> (k * SEG));
      b_seg = SEG'(pb >> (k * SEG));
      sum   = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, pc};
      nacc  = pa;
      nacc[k*SEG +: SEG] = sum[SEG-1:0];
      if (advance) begin
        acc_d[k] = nacc;
        opb_d[k] = pb;
        cry_d[k] = sum[SEG];
        vld_d[k] = pv;
      end
    end

    // pa/pb/nacc now describe the final stage; A's MSB is still intact in pa.
    if (advance) begin
      ovf_d  = (pa[WIDTH-1] == pb[WIDTH-1]) && (nacc[WIDTH-1] != pa[WIDTH-1]);
      zero_d = (nacc == '0);
    end
  end

  // Pipeline state; reset discards every in-flight beat and clears the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        opb_q[k] <= '0;
      end
      cry_q  <= '0;
      vld_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      cry_q  <= cry_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus_io.in_ready  = advance;
  assign bus_io.out_valid = vld_q[STAGES-1];
  assign bus_io.y         = acc_q[STAGES-1];
  assign bus_io.carry_out = cry_q[STAGES-1];
  assign bus_io.overflow  = ovf_q;
  assign bus_io.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 32-bit/4-stage unit plus an 8-bit/1-stage instance.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] y;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;
  res_t        exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus32)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus8)
  );

  // Reference: exact integer arithmetic, then reduce to the hardware view.
  function automatic res_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input logic sub);
    res_t   m;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint c  = longint'(cin);
    longint r;
    longint s;
    if (!sub) begin
      r      = ua + ub + c;
      m.y    = r[31:0];
      m.cout = r[32];
      s      = sa + sb + c;
    end else begin
      r      = ua - ub - c;
      m.y    = r[31:0];
      m.cout = (ua >= ub + c);
      s      = sa - sb - c;
    end
    m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return m;
  endfunction

  // Drive one cycle (called at a falling edge), sample outputs, return at the next falling edge.
  task automatic cycle32(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic ordy,
                         output logic ir, output logic ov, output res_t obs, output logic oz);
    bus32.in_valid  = iv;
    bus32.a         = a;
    bus32.b         = b;
    bus32.carry_in  = cin;
    bus32.op_sub    = sub;
    bus32.out_ready = ordy;
    #1;
    ir       = bus32.in_ready;
    ov       = bus32.out_valid;
    obs.y    = bus32.y;
    obs.cout = bus32.carry_out;
    obs.ovf  = bus32.overflow;
    oz       = bus32.zero;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus32.in_valid  = 1'b1;
    bus32.a         = $urandom;
    bus32.b         = $urandom;
    bus32.out_ready = 1'b0;
    bus8.in_valid   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus32.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
    #1;
    total++;
    if (bus32.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid);
    end
    total++;
    if (bus32.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready);
    end
    total++;
    if ({bus32.y, bus32.carry_out, bus32.overflow, bus32.zero} !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got y=%h c=%b o=%b z=%b want all 0",
               bus32.y, bus32.carry_out, bus32.overflow, bus32.zero);
    end
    total++;
    if (bus8.out_valid !== 1'b0 || bus8.y !== 8'h00) begin
      bad++; $display("FAIL reset_w8: got v=%b y=%h want v=0 y=00", bus8.out_valid, bus8.y);
    end
    @(negedge clk);
  endtask

  // Single beats with known answers; also measures latency.
  task automatic test_directed();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        ts [3];
    logic [31:0] ey [3];
    logic        ec [3];
    logic        eo [3];
    logic        ez [3];
    logic        ir, ov, oz;
    res_t        obs;
    int          lat;
    ta = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
    tb = '{32'd1, 32'd1, 32'd7};
    ts = '{1'b0, 1'b1, 1'b1};
    ey = '{32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
    ec = '{1'b1, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b0};
    ez = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle32(1'b1, ta[i], tb[i], 1'b0, ts[i], 1'b1, ir, ov, obs, oz);
      total++;
      if (ir !== 1'b1) begin
        bad++; $display("FAIL directed%0d_in_ready: got %b want 1", i, ir);
      end
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
        cycle32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, ir, ov, obs, oz);
        if (ov === 1'b1) begin
          lat = k;
          break;
        end
      end
      total++;
      if (lat != 4) begin
        bad++; $display("FAIL directed%0d_latency: got %0d want 4", i, lat);
      end
      total++;
      if (obs.y !== ey[i] || obs.cout !== ec[i] || obs.ovf !== eo[i] || oz !== ez[i]) begin
        bad++;
        $display("FAIL directed%0d_result: got y=%h c=%b o=%b z=%b want y=%h c=%b o=%b z=%b",
                 i, obs.y, obs.cout, obs.ovf, oz, ey[i], ec[i], eo[i], ez[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ir, ov, oz, iv, cin, sub;
    logic [31:0] a, b;
    res_t        obs, e;
    int          got = 0;
    exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      iv  = (c < 16);
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      cycle32(iv, a, b, cin, sub, 1'b1, ir, ov, obs, oz);
      if (iv) begin
        total++;
        if (ir !== 1'b1) begin
          bad++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", c, ir);
        end
        if (ir === 1'b1) exp_q.push_back(ref_result(a, b, cin, sub));
      end
      if (ov === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: cycle %0d got unexpected result y=%h want none", c,
                          obs.y);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e || oz !== (e.y == 32'd0)) begin
            bad++;
            $display("FAIL b2b_result%0d: got y=%h c=%b o=%b z=%b want y=%h c=%b o=%b z=%b",
                     got, obs.y, obs.cout, obs.ovf, oz, e.y, e.cout, e.ovf, e.y == 32'd0);
          end
        end
        total++;
        if (c != got + 4) begin
          bad++; $display("FAIL b2b_timing%0d: got cycle %0d want %0d", got, c, got + 4);
        end
        got++;
      end
    end
    total++;
    if (got != 16) begin
      bad++; $display("FAIL b2b_count: got %0d want 16", got);
    end
  endtask

  task automatic test_backpressure();
    logic        ir, ov, oz, iv, cin, sub, ordy;
    logic        hold_prev = 1'b0;
    logic [31:0] a, b;
    res_t        obs, e, prev;
    logic        prev_z = 1'b0;
    exp_q.delete();
    prev = '0;
    for (int c = 0; c < 320; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      cin  = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      cycle32(iv, a, b, cin, sub, ordy, ir, ov, obs, oz);
      total++;
      if (ir !== (!ov || ordy)) begin
        bad++; $display("FAIL bp_in_ready: cycle %0d got %b want %b", c, ir, !ov || ordy);
      end
      if (hold_prev) begin
        total++;
        if (ov !== 1'b1 || obs !== prev || oz !== prev_z) begin
          bad++;
          $display("FAIL bp_hold: cycle %0d got v=%b y=%h want v=1 y=%h", c, ov, obs.y, prev.y);
        end
      end
      if (iv && ir === 1'b1) exp_q.push_back(ref_result(a, b, cin, sub));
      if (ov === 1'b1 && ordy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra: cycle %0d got y=%h want none", c, obs.y);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e || oz !== (e.y == 32'd0)) begin
            bad++;
            $display("FAIL bp_result: cycle %0d got y=%h c=%b o=%b want y=%h c=%b o=%b",
                     c, obs.y, obs.cout, obs.ovf, e.y, e.cout, e.ovf);
          end
        end
      end
      hold_prev = (ov === 1'b1) && !ordy;
      prev      = obs;
      prev_z    = oz;
    end
    for (int c = 0; c < 20; c++) begin
      cycle32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, ir, ov, obs, oz);
      if (ov === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_drain_extra: got y=%h want none", obs.y);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++; $display("FAIL bp_drain_result: got y=%h want y=%h", obs.y, e.y);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL bp_lost: got %0d beats outstanding want 0", exp_q.size());
    end
  endtask

  // Reset with beats in flight: once free-flowing, once with the pipe stalled full.
  task automatic test_reset_flush();
    logic ir, ov, oz, ordy;
    res_t obs;
    int   n;
    for (int scen = 0; scen < 2; scen++) begin
      ordy = (scen == 0);
      n    = (scen == 0) ? 3 : 6;
      for (int i = 0; i < n; i++) begin
        cycle32(1'b1, $urandom, $urandom, 1'b0, 1'b0, ordy, ir, ov, obs, oz);
      end
      rst = 1'b1;
      cycle32(1'b1, $urandom, $urandom, 1'b1, 1'b0, ordy, ir, ov, obs, oz);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
        cycle32(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, ir, ov, obs, oz);
        total++;
        if (ov !== 1'b0) begin
          bad++; $display("FAIL flush%0d_stale: cycle %0d got out_valid=%b want 0", scen, c, ov);
        end
        if (c == 0) begin
          total++;
          if (obs !== '0 || oz !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL flush%0d_cleared: got y=%h c=%b o=%b z=%b rdy=%b want 0/0/0/0/1",
                     scen, obs.y, obs.cout, obs.ovf, oz, ir);
          end
        end
      end
    end
  endtask

  task automatic test_w8_s1();
    bus8.in_valid  = 1'b1;
    bus8.a         = 8'h7F;
    bus8.b         = 8'h01;
    bus8.carry_in  = 1'b1;
    bus8.op_sub    = 1'b0;
    bus8.out_ready = 1'b1;
    #1;
    total++;
    if (bus8.in_ready !== 1'b1) begin
      bad++; $display("FAIL w8_in_ready: got %b want 1", bus8.in_ready);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1;
    total++;
    if (bus8.out_valid !== 1'b1 || bus8.y !== 8'h81 || bus8.overflow !== 1'b1 ||
        bus8.carry_out !== 1'b0 || bus8.zero !== 1'b0) begin
      bad++;
      $display("FAIL w8_result: got v=%b y=%h o=%b c=%b z=%b want v=1 y=81 o=1 c=0 z=0",
               bus8.out_valid, bus8.y, bus8.overflow, bus8.carry_out, bus8.zero);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus8.out_valid !== 1'b0) begin
      bad++; $display("FAIL w8_single: got out_valid=%b want 0", bus8.out_valid);
    end
    @(negedge clk);
  endtask

  initial begin
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.carry_in  = 1'b0;
    bus32.op_sub    = 1'b0;
    bus32.out_ready = 1'b1;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.carry_in   = 1'b0;
    bus8.op_sub     = 1'b0;
    bus8.out_ready  = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_w8_s1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
